// File: rtl/seq_run_ctrl_if.sv
// seq_run_ctrl_if: control inputs and status outputs of the sequence run controller
interface seq_run_ctrl_if;
  logic start, stop, hold, step_mode, step, load;
  logic [3:0] run_len, load_val;
  logic [3:0] q, adv_cnt;
  logic busy, done, wrap, err;
  modport master (
    output start, stop, hold, step_mode, step, load, run_len, load_val,
    input  q, adv_cnt, busy, done, wrap, err
  );
  modport slave (
    input  start, stop, hold, step_mode, step, load, run_len, load_val,
    output q, adv_cnt, busy, done, wrap, err
  );
endinterface

// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: steps q through an 8-code cycle in runs of run_len advances
module seq_run_ctrl #(
  parameter logic [3:0] RESET_CODE = 4'b0000
) (
  input logic clk,
  input logic clear,
  seq_run_ctrl_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [3:0] len_r;
  logic [3:0] cnt1;
  logic en;
  // illegal codes map to themselves, so a code is legal iff it moves
  function automatic logic [3:0] nxt(input logic [3:0] c);
    case (c)
      4'b0000: nxt = 4'b1101;
      4'b1101: nxt = 4'b1011;
      4'b1011: nxt = 4'b1001;
      4'b1001: nxt = 4'b0110;
      4'b0110: nxt = 4'b1100;
      4'b1100: nxt = 4'b0011;
      4'b0011: nxt = 4'b1111;
      4'b1111: nxt = 4'b0000;
      default: nxt = c;
    endcase
  endfunction
  always_comb begin
    en = bus.step_mode ? bus.step : ~bus.hold;
    cnt1 = bus.adv_cnt + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      bus.q <= RESET_CODE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.wrap <= 1'b0;
      bus.err <= 1'b0;
      bus.adv_cnt <= 4'd0;
      len_r <= 4'd0;
    end else begin
      bus.done <= 1'b0;
      bus.wrap <= 1'b0;
      if (state == IDLE) begin
        if (bus.load) begin
          if (nxt(bus.load_val) != bus.load_val) bus.q <= bus.load_val;
          else bus.err <= 1'b1;
        end else if (bus.start && !bus.stop) begin
          state <= RUN;
          bus.busy <= 1'b1;
          len_r <= bus.run_len;
          bus.adv_cnt <= 4'd0;
          bus.err <= 1'b0;
        end
      end else if (bus.stop) begin
        state <= IDLE;
        bus.busy <= 1'b0;
      end else if (en) begin
        bus.q <= nxt(bus.q);
        bus.adv_cnt <= cnt1;
        bus.wrap <= bus.q == 4'b1111;
        if (len_r != 4'd0 && cnt1 == len_r) begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_run_ctrl.sv
// tb_seq_run_ctrl: table-driven vectors plus directed multi-cycle sequences
module tb_seq_run_ctrl;
  logic clk = 1'b0;
  logic clear = 1'b0;
  int pass = 0;
  int total = 0;
  int id = 0;
  always #5 clk = ~clk;
  seq_run_ctrl_if bus ();
  seq_run_ctrl dut (.clk(clk), .clear(clear), .bus(bus));
  typedef struct {
    logic c, st, sp, h, sm, s, ld;
    logic [3:0] len, lv;
    logic [3:0] q;
    logic b, d, w, e;
    logic [3:0] a;
  } vec_t;
  vec_t vecs[$];
  logic [3:0] seq [8] = '{4'h0, 4'hD, 4'hB, 4'h9, 4'h6, 4'hC, 4'h3, 4'hF};
  function automatic vec_t mk(logic c, st, sp, h, sm, s, ld, logic [3:0] len, lv,
                              logic [3:0] q, logic b, d, w, e, logic [3:0] a);
    vec_t v;
    v.c = c; v.st = st; v.sp = sp; v.h = h; v.sm = sm; v.s = s; v.ld = ld;
    v.len = len; v.lv = lv; v.q = q; v.b = b; v.d = d; v.w = w; v.e = e; v.a = a;
    return v;
  endfunction
  task automatic apply(input vec_t v);
    logic [11:0] act, exp;
    clear = v.c; bus.start = v.st; bus.stop = v.sp; bus.hold = v.h;
    bus.step_mode = v.sm; bus.step = v.s; bus.load = v.ld;
    bus.run_len = v.len; bus.load_val = v.lv;
    @(posedge clk);
    #1;
    act = {bus.q, bus.busy, bus.done, bus.wrap, bus.err, bus.adv_cnt};
    exp = {v.q, v.b, v.d, v.w, v.e, v.a};
    total++;
    if (act === exp) pass++;
    else $display("FAIL vec%0d {q,busy,done,wrap,err,adv_cnt}: got %h/%b%b%b%b/%h want %h/%b%b%b%b/%h",
                  id, act[11:8], act[7], act[6], act[5], act[4], act[3:0],
                  exp[11:8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    id++;
  endtask
  initial begin
    //            c st sp h sm s ld len lv    q     b d w e a
    vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0, 4'h0, 0,0,0,0, 0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 8, 0, 4'h0, 1,0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8, 0, 4'hD, 1,0,0,0, 1));
    vecs.push_back(mk(0,0,0,1,0,0,0, 8, 0, 4'hD, 1,0,0,0, 1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8, 0, 4'hB, 1,0,0,0, 2));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8, 0, 4'h9, 1,0,0,0, 3));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8, 0, 4'h6, 1,0,0,0, 4));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8, 0, 4'hC, 1,0,0,0, 5));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8, 0, 4'h3, 1,0,0,0, 6));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8, 0, 4'hF, 1,0,0,0, 7));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8, 0, 4'h0, 0,1,1,0, 8));
    vecs.push_back(mk(0,0,0,0,0,0,0, 8, 0, 4'h0, 0,0,0,0, 8));
    vecs.push_back(mk(0,0,0,0,0,0,1, 8, 5, 4'h0, 0,0,0,1, 8));
    vecs.push_back(mk(0,1,0,0,0,0,1, 2, 9, 4'h9, 0,0,0,1, 8));
    vecs.push_back(mk(0,1,0,0,0,0,0, 2, 0, 4'h9, 1,0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 2, 0, 4'h6, 1,0,0,0, 1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 2, 0, 4'hC, 0,1,0,0, 2));
    vecs.push_back(mk(0,0,0,0,0,0,0, 2, 0, 4'hC, 0,0,0,0, 2));
    vecs.push_back(mk(0,1,1,0,0,0,0, 2, 0, 4'hC, 0,0,0,0, 2));
    vecs.push_back(mk(0,0,0,0,0,0,1, 2, 4'hA, 4'hC, 0,0,0,1, 2));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    // step mode: advances only on step cycles, done after the second
    apply(mk(1,0,0,0,0,0,0, 0, 0, 4'h0, 0,0,0,0, 0));
    apply(mk(0,1,0,0,1,0,0, 2, 0, 4'h0, 1,0,0,0, 0));
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) apply(mk(0,0,0,0,1,0,0, 2, 0, k ? 4'hD : 4'h0, 1,0,0,0, 4'(k)));
      apply(mk(0,0,0,0,1,1,0, 2, 0, k ? 4'hB : 4'hD, k ? 1'b0 : 1'b1, 1'(k), 0, 0, 4'(k + 1)));
    end
    apply(mk(0,0,0,0,1,1,0, 2, 0, 4'hB, 0,0,0,0, 2));
    // continuous run: adv_cnt wraps 15->0, wrap pulses each pass through 0000, then stop
    apply(mk(1,0,0,0,0,0,0, 0, 0, 4'h0, 0,0,0,0, 0));
    apply(mk(0,1,0,0,0,0,0, 0, 0, 4'h0, 1,0,0,0, 0));
    for (int i = 1; i <= 19; i++)
      apply(mk(0,0,0,0,0,0,0, 0, 0, seq[i % 8], 1, 0, (i % 8) == 0, 0, 4'(i % 16)));
    apply(mk(0,0,1,0,0,0,0, 0, 0, 4'h9, 0,0,0,0, 3));
    apply(mk(0,0,0,0,0,0,0, 0, 0, 4'h9, 0,0,0,0, 3));
    apply(mk(0,1,1,0,0,0,0, 0, 0, 4'h9, 0,0,0,0, 3));
    // clear mid-run while held
    apply(mk(0,1,0,0,0,0,0, 0, 0, 4'h9, 1,0,0,0, 0));
    apply(mk(0,0,0,0,0,0,0, 0, 0, 4'h6, 1,0,0,0, 1));
    apply(mk(0,0,0,1,0,0,0, 0, 0, 4'h6, 1,0,0,0, 1));
    apply(mk(1,0,0,1,0,0,0, 0, 0, 4'h0, 0,0,0,0, 0));
    apply(mk(0,0,0,1,0,0,0, 0, 0, 4'h0, 0,0,0,0, 0));
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/seq_run_ctrl.md
SEQ_RUN_CTRL -- requirements
Module: seq_run_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_CODE, default 4'b0000: the q value after reset; it SHALL be one of the eight legal codes.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: begin a run; sampled in IDLE only.
REQ-005 The block SHALL have port stop, input, 1 bit: abort the current run.
REQ-006 The block SHALL have port hold, input, 1 bit: freeze advancing while in RUN with step_mode=0.
REQ-007 The block SHALL have port step_mode, input, 1 bit: 1 = advance only on step.
REQ-008 The block SHALL have port step, input, 1 bit: single-advance request, level-sampled each cycle.
REQ-009 The block SHALL have port run_len, input, 4 bits: number of advances per run; 0 = continuous.
REQ-010 The block SHALL have port load, input, 1 bit: preset q from load_val; honoured in IDLE only.
REQ-011 The block SHALL have port load_val, input, 4 bits: preset code.
REQ-012 The block SHALL have port q, output, 4 bits: current sequence code, q[3] MSB.
REQ-013 The block SHALL have port busy, output, 1 bit: 1 while in RUN.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse at normal run completion.
REQ-015 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when an advance takes q from 1111 to 0000.
REQ-016 The block SHALL have port err, output, 1 bit: sticky flag for an illegal load.
REQ-017 The block SHALL have port adv_cnt, output, 4 bits: advances completed in the current or last run.

Function
REQ-018 The legal sequence SHALL be 0000->1101->1011->1001->0110->1100->0011->1111->0000; the other 8 codes are illegal.
REQ-019 The FSM SHALL have exactly two states, IDLE and RUN; all outputs SHALL be registered.
REQ-020 In IDLE with start=1 and stop=0, the block SHALL go to RUN with busy=1 after the edge, latch run_len into len_r, clear adv_cnt to 0 and clear err.
REQ-021 In IDLE with start=1 and stop=1 in the same cycle, stop SHALL win: the block stays in IDLE and nothing changes.
REQ-022 In RUN, the advance enable SHALL be step when step_mode=1, else ~hold; when enabled, q <= next(q) and adv_cnt <= adv_cnt+1 (mod 16).
REQ-023 In RUN, if an advance makes adv_cnt+1 == len_r and len_r != 0, the block SHALL go to IDLE with busy=0 and done=1 after that same edge.
REQ-024 When len_r == 0, the run SHALL be continuous: adv_cnt wraps 15->0 and the run ends only on stop or clear.
REQ-025 In RUN with stop=1, the block SHALL go to IDLE after the edge with no advance that cycle, done=0, and q and adv_cnt held; stop SHALL take priority over advance.
REQ-026 In IDLE with load=1 and a legal load_val, q SHALL be set to load_val after the edge.
REQ-027 In IDLE with load=1 and an illegal load_val, q SHALL be unchanged and err SHALL be set to 1.
REQ-028 When load=1 and start=1 in the same IDLE cycle, the load SHALL apply, and the run SHALL start from the loaded code on the next edge only if start is still high; start SHALL be ignored in the load cycle.
REQ-029 load and start SHALL be ignored while in RUN.
REQ-030 wrap SHALL be 1 for exactly the cycle after an advance from 1111 to 0000, including one that coincides with done.
REQ-031 done and wrap SHALL otherwise be 0; err SHALL clear only on clear or on an accepted start.
REQ-032 Latency from start to the first possible q change SHALL be 2 edges: the start edge enters RUN and the next enabled edge advances.

Reset
REQ-033 With clear=1 at an edge, the block SHALL go to IDLE with q=RESET_CODE, busy=0, done=0, wrap=0, err=0, adv_cnt=0 and len_r=0, regardless of state or other inputs, including mid-run.

Verification
REQ-034 The bench SHALL cover reset: clear=1 for 1 cycle -> q=0000, busy=0, done=0, wrap=0, err=0, adv_cnt=0.
REQ-035 The bench SHALL cover a free run: run_len=8, step_mode=0, hold=0, start pulse -> q steps through all 7 following codes back to 0000; wrap and done are both 1 in the same cycle; adv_cnt=8 and busy=0.
REQ-036 The bench SHALL cover step mode: step_mode=1, run_len=2, step pulsed twice with 3 idle cycles between -> q goes 0000->1101->1011 only on step cycles; done follows the second step.
REQ-037 The bench SHALL cover load: load 0101 -> err=1 and q unchanged; load 1001 -> q=1001; start -> err=0 and the first advance gives 0110.
REQ-038 The bench SHALL cover stop: run_len=0 with stop after 3 advances -> q=1001, busy=0, done=0, adv_cnt=3 held; start with stop in the same cycle -> stays IDLE.
REQ-039 The bench SHALL cover clear mid-run: clear=1 during RUN with hold=1 -> all reset values on the next cycle, with no done or wrap pulse.
